// File: rtl/gpu_pkg.sv
// gpu_pkg: instruction width, field layout and struct shared by the FIFO and decode stages.
package gpu_pkg;
  localparam int INST_W = 82;
  localparam int INST_TYPE_LSB = 80;
  localparam int FILL_TYPE_LSB = 79;
  localparam int LAYER_NUM_LSB = 76;
  localparam int VERTICE_NUM_LSB = 74;
  localparam int COLOR_CODE_LSB = 66;
  localparam int TEXTURE_CODE_LSB = 62;
  localparam int ALPHA_VAL_LSB = 54;
  localparam int COORDINATES_LSB = 0;
  typedef struct packed {
    logic [1:0]  inst_type;
    logic        fill_type;
    logic [2:0]  layer_num;
    logic [1:0]  vertice_num;
    logic [7:0]  color_code;
    logic [3:0]  texture_code;
    logic [7:0]  alpha_val;
    logic [53:0] coordinates;
  } inst_t;
endpackage

// File: rtl/inst_fifo_if.sv
// inst_fifo_if: push/pop/flush bus between the host writer, the controller and the instruction FIFO.
import gpu_pkg::*;
interface inst_fifo_if #(parameter int DEPTH = 8);
  localparam int ADDR_W = $clog2(DEPTH);
  logic              w_enable;
  logic [INST_W-1:0] w_data;
  logic              r_enable;
  logic              flush;
  logic [INST_W-1:0] r_data;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;
  modport master (output w_enable, w_data, r_enable, flush,
                  input r_data, empty, full, count, overflow, underflow);
  modport slave (input w_enable, w_data, r_enable, flush,
                 output r_data, empty, full, count, overflow, underflow);
endinterface

// File: rtl/fifo_mem.sv
// fifo_mem: unreset register array with one synchronous write port and one combinational read port.
import gpu_pkg::*;
module fifo_mem #(
  parameter int DEPTH = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [INST_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [INST_W-1:0] rdata_o
);
  logic [INST_W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/inst_fifo.sv
// inst_fifo: first-word-fall-through instruction FIFO with sticky overflow/underflow and synchronous flush.
import gpu_pkg::*;
module inst_fifo #(
  parameter int DEPTH = 8
) (
  input logic       clk,
  input logic       n_rst,
  inst_fifo_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              empty, full, push, pop;
  logic [INST_W-1:0] head;
  assign empty = count_q == '0;
  assign full = count_q == FULL_CNT;
  assign pop = bus.r_enable && !empty;
  // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign push = bus.w_enable && (!full || pop);
  always_comb begin
    wr_ptr_d = bus.flush ? '0 : push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d = bus.flush ? '0 : pop ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    count_d = bus.flush ? '0 : (push && !pop) ? count_q + (ADDR_W+1)'(1) :
              (pop && !push) ? count_q - (ADDR_W+1)'(1) : count_q;
    ovf_d = !bus.flush && (ovf_q || (bus.w_enable && !push));
    unf_d = !bus.flush && (unf_q || (bus.r_enable && empty));
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
  fifo_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk     (clk),
    .we_i    (push && !bus.flush),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.w_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );
  assign bus.r_data = empty ? '0 : head;
  assign bus.empty = empty;
  assign bus.full = full;
  assign bus.count = count_q;
  assign bus.overflow = ovf_q;
  assign bus.underflow = unf_q;
endmodule

// File: tb/tb_inst_fifo.sv
// tb_inst_fifo: constant vector table, directed corner sequences and random traffic against a queue model.
import gpu_pkg::*;
module tb_inst_fifo;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int checks = 0;
  int errors = 0;
  inst_fifo_if #(.DEPTH(8)) bus ();
  inst_fifo #(.DEPTH(8)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));
  always #5 clk = ~clk;

  logic [INST_W-1:0] mq[$];
  bit m_ovf, m_unf;

  typedef struct {
    bit we;
    logic [INST_W-1:0] wd;
    bit re;
    bit fl;
    int exp_count;
    logic [INST_W-1:0] exp_rdata;
    bit exp_ovf;
    bit exp_unf;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string nm, input logic [INST_W-1:0] act, input logic [INST_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit we, input logic [INST_W-1:0] wd, input bit re, input bit fl);
    bit p, q;
    if (fl) begin
      mq.delete();
      m_ovf = 0;
      m_unf = 0;
    end else begin
      p = re && mq.size() > 0;
      q = we && (mq.size() < 8 || p);
      if (re && mq.size() == 0) m_unf = 1;
      if (we && !q) m_ovf = 1;
      if (p) void'(mq.pop_front());
      if (q) mq.push_back(wd);
    end
  endtask

  task automatic check_model(input string nm);
    chk({nm, ".count"}, INST_W'(bus.count), INST_W'(mq.size()));
    chk({nm, ".empty"}, INST_W'(bus.empty), INST_W'(mq.size() == 0));
    chk({nm, ".full"}, INST_W'(bus.full), INST_W'(mq.size() == 8));
    chk({nm, ".r_data"}, bus.r_data, mq.size() > 0 ? mq[0] : '0);
    chk({nm, ".overflow"}, INST_W'(bus.overflow), INST_W'(m_ovf));
    chk({nm, ".underflow"}, INST_W'(bus.underflow), INST_W'(m_unf));
  endtask

  task automatic step(input bit we, input logic [INST_W-1:0] wd, input bit re, input bit fl);
    bus.w_enable = we;
    bus.w_data = wd;
    bus.r_enable = re;
    bus.flush = fl;
    @(posedge clk);
    #1;
    model_step(we, wd, re, fl);
  endtask

  task automatic mstep(input string nm, input bit we, input logic [INST_W-1:0] wd, input bit re, input bit fl);
    step(we, wd, re, fl);
    check_model(nm);
  endtask

  initial begin
    logic [INST_W-1:0] v;
    bus.w_enable = 0;
    bus.w_data = '0;
    bus.r_enable = 0;
    bus.flush = 0;
    #3;
    chk("rst.empty", INST_W'(bus.empty), INST_W'(1));
    chk("rst.count", INST_W'(bus.count), '0);
    chk("rst.r_data", bus.r_data, '0);
    chk("rst.full", INST_W'(bus.full), '0);
    chk("rst.flags", INST_W'({bus.overflow, bus.underflow}), '0);
    @(negedge clk);
    n_rst = 1;

    for (int i = 1; i <= 8; i++)
      vecs.push_back('{1, INST_W'(i), 0, 0, i, INST_W'(1), 0, 0});
    vecs.push_back('{1, INST_W'('hDEAD), 0, 0, 8, INST_W'(1), 1, 0});
    vecs.push_back('{1, INST_W'('hAA), 1, 0, 8, INST_W'(2), 1, 0});
    vecs.push_back('{0, '0, 0, 1, 0, '0, 0, 0});
    vecs.push_back('{1, INST_W'('h55), 1, 0, 1, INST_W'('h55), 0, 1});
    vecs.push_back('{0, '0, 1, 0, 0, '0, 0, 1});
    vecs.push_back('{0, '0, 0, 1, 0, '0, 0, 0});
    foreach (vecs[i]) begin
      step(vecs[i].we, vecs[i].wd, vecs[i].re, vecs[i].fl);
      chk($sformatf("vec%0d.count", i), INST_W'(bus.count), INST_W'(vecs[i].exp_count));
      chk($sformatf("vec%0d.r_data", i), bus.r_data, vecs[i].exp_rdata);
      chk($sformatf("vec%0d.empty", i), INST_W'(bus.empty), INST_W'(vecs[i].exp_count == 0));
      chk($sformatf("vec%0d.full", i), INST_W'(bus.full), INST_W'(vecs[i].exp_count == 8));
      chk($sformatf("vec%0d.overflow", i), INST_W'(bus.overflow), INST_W'(vecs[i].exp_ovf));
      chk($sformatf("vec%0d.underflow", i), INST_W'(bus.underflow), INST_W'(vecs[i].exp_unf));
    end
    mq.delete();
    m_ovf = 0;
    m_unf = 0;

    for (int i = 1; i <= 8; i++) mstep("fill", 1, INST_W'(i), 0, 0);
    mstep("ovf_push", 1, INST_W'('hDEAD), 0, 0);
    for (int i = 1; i <= 8; i++) begin
      chk("drain.order", bus.r_data, INST_W'(i));
      mstep("drain", 0, '0, 1, 0);
    end
    mstep("ovf_flush", 0, '0, 0, 1);
    for (int i = 1; i <= 8; i++) mstep("refill", 1, INST_W'(i), 0, 0);
    mstep("full_push_pop", 1, INST_W'('hAA), 1, 0);
    for (int i = 0; i < 7; i++) mstep("pop_to_aa", 0, '0, 1, 0);
    chk("aa_at_head", bus.r_data, INST_W'('hAA));
    mstep("pop_aa", 0, '0, 1, 0);
    mstep("empty_push_pop", 1, INST_W'('h55), 1, 0);
    mstep("pop_55", 0, '0, 1, 0);

    for (int i = 0; i < 20; i++) begin
      v = INST_W'(100 + i);
      mstep("wrap_push", 1, v, 0, 0);
      chk("wrap.last", bus.r_data, v);
      mstep("wrap_pop", 0, '0, 1, 0);
    end

    mstep("clr", 0, '0, 0, 1);
    for (int i = 1; i <= 5; i++) mstep("pre_flush", 1, INST_W'(i), 0, 0);
    mstep("flush_prio", 1, INST_W'('h77), 1, 1);
    chk("flush_prio.count", INST_W'(bus.count), '0);
    mstep("flush_after", 0, '0, 0, 0);
    chk("flush_after.r_data", bus.r_data, '0);

    mstep("unf_set", 0, '0, 1, 0);
    for (int i = 1; i <= 3; i++) mstep("pre_rst", 1, INST_W'('h30 + i), 0, 0);
    #2;
    n_rst = 0;
    #1;
    chk("async_rst.empty", INST_W'(bus.empty), INST_W'(1));
    chk("async_rst.count", INST_W'(bus.count), '0);
    chk("async_rst.r_data", bus.r_data, '0);
    chk("async_rst.overflow", INST_W'(bus.overflow), '0);
    chk("async_rst.underflow", INST_W'(bus.underflow), '0);
    mq.delete();
    m_ovf = 0;
    m_unf = 0;
    @(negedge clk);
    n_rst = 1;

    for (int i = 0; i < 400; i++) begin
      v = {18'($urandom), $urandom, $urandom};
      mstep("rand", 1'($urandom_range(0, 1)), v, 1'($urandom_range(0, 1)), $urandom_range(0, 31) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
